// File: rtl/output_arbiter.sv
// Round-robin output-port arbiter: picks one input controller whose route code
// targets this port, forwards its flit to the output FIFO, then idles one cycle.
module output_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_PORT     = 5,
  parameter logic [2:0]  PORT_ID    = 3'b000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT*3-1:0]          req_route,
  input  logic [N_PORT*DATA_WIDTH-1:0] req_data,
  input  logic                         full,
  output logic [DATA_WIDTH-1:0]        Data_out,
  output logic                         wr,
  output logic [N_PORT-1:0]            s_ack,
  output logic [2:0]                   grant_id,
  output logic [7:0]                   flit_cnt
);

  localparam logic [2:0] NO_GRANT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state;
  logic [2:0]              ptr;
  logic [N_PORT-1:0]       valid;
  logic                    found;
  logic [2:0]              win;
  logic [DATA_WIDTH-1:0]   win_data;
  int unsigned             idx;

  // A requester is valid only when its route code names this port.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < N_PORT; i++) begin
      valid[i] = (req_route[3*i +: 3] == PORT_ID);
    end
  end

  // Round-robin search starting one past the last served index.
  always_comb begin
    found    = 1'b0;
    win      = NO_GRANT;
    win_data = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= N_PORT; k++) begin
      idx = (32'(ptr) + k) % N_PORT;
      for (int unsigned i = 0; i < N_PORT; i++) begin
        if (!found && (i == idx) && valid[i]) begin
          found    = 1'b1;
          win      = 3'(i);
          win_data = req_data[DATA_WIDTH*i +: DATA_WIDTH];
        end
      end
    end
  end

  // Write strobe and acknowledge follow full combinationally while sending.
  always_comb begin
    wr    = (state == SEND) && !full;
    s_ack = '0;
    for (int unsigned i = 0; i < N_PORT; i++) begin
      s_ack[i] = wr && (grant_id == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'(N_PORT - 1);
      Data_out <= '0;
      grant_id <= NO_GRANT;
      flit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= SEND;
            grant_id <= win;
            Data_out <= win_data;
          end else begin
            grant_id <= NO_GRANT;
          end
        end
        SEND: begin
          // Flit is latched, so a withdrawn request cannot cancel or repeat it.
          if (!full) begin
            ptr      <= grant_id;
            flit_cnt <= flit_cnt + 8'd1;
            grant_id <= NO_GRANT;
            state    <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          grant_id <= NO_GRANT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: single send, round-robin order,
// backpressure, foreign routes, reset mid-send and counter wrap.
module tb_output_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 5;

  logic             clk;
  logic             rst;
  logic [NP*3-1:0]  req_route;
  logic [NP*DW-1:0] req_data;
  logic             full;
  logic [DW-1:0]    Data_out;
  logic             wr;
  logic [NP-1:0]    s_ack;
  logic [2:0]       grant_id;
  logic [7:0]       flit_cnt;

  int n_vec;
  int n_err;

  output_arbiter #(
    .DATA_WIDTH (DW),
    .N_PORT     (NP),
    .PORT_ID    (3'b000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_route (req_route),
    .req_data  (req_data),
    .full      (full),
    .Data_out  (Data_out),
    .wr        (wr),
    .s_ack     (s_ack),
    .grant_id  (grant_id),
    .flit_cnt  (flit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic [2:0] code, input logic [7:0] data);
    req_route[3*p +: 3]  = code;
    req_data[DW*p +: DW] = data;
  endtask

  task automatic all_idle();
    req_route = {NP{3'b111}};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] rr_order [4];
  logic [7:0] rr_data  [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    full = 1'b0;
    req_route = {NP{3'b111}};
    req_data = '0;
    rr_order = '{3'd1, 3'd3, 3'd4, 3'd1};
    rr_data  = '{8'h11, 8'h33, 8'h44, 8'h11};

    // Reset state
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_grant", 32'(grant_id), 32'h7);
    check("rst_data", 32'(Data_out), 32'h0);
    check("rst_cnt", 32'(flit_cnt), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_ack", 32'(s_ack), 32'h0);

    // Single request from local port; withdrawn while in SEND
    set_port(0, 3'b000, 8'h05);
    cyc();
    check("single_data", 32'(Data_out), 32'h05);
    check("single_grant", 32'(grant_id), 32'h0);
    check("single_wr", 32'(wr), 32'h1);
    check("single_ack", 32'(s_ack), 32'h01);
    all_idle();
    cyc();
    check("gap_wr", 32'(wr), 32'h0);
    check("gap_ack", 32'(s_ack), 32'h0);
    check("gap_grant", 32'(grant_id), 32'h7);
    check("gap_cnt", 32'(flit_cnt), 32'h1);
    cyc();
    check("idle_wr", 32'(wr), 32'h0);
    check("idle_grant", 32'(grant_id), 32'h7);
    check("idle_hold_data", 32'(Data_out), 32'h05);

    // Round-robin among ports 1, 3, 4
    set_port(1, 3'b000, 8'h11);
    set_port(3, 3'b000, 8'h33);
    set_port(4, 3'b000, 8'h44);
    for (int g = 0; g < 4; g++) begin
      cyc();
      check($sformatf("rr%0d_grant", g), 32'(grant_id), 32'(rr_order[g]));
      check($sformatf("rr%0d_data", g), 32'(Data_out), 32'(rr_data[g]));
      check($sformatf("rr%0d_wr", g), 32'(wr), 32'h1);
      check($sformatf("rr%0d_ack", g), 32'(s_ack), 32'h1 << rr_order[g]);
      cyc();
      check($sformatf("rr%0d_gap_wr", g), 32'(wr), 32'h0);
      if (g == 3) all_idle();
      cyc();
      check($sformatf("rr%0d_idle_wr", g), 32'(wr), 32'h0);
    end
    check("rr_cnt", 32'(flit_cnt), 32'h5);

    // Backpressure: full held for 4 cycles in SEND
    full = 1'b1;
    set_port(2, 3'b000, 8'h22);
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (c == 0) set_port(2, 3'b000, 8'h99);
      check($sformatf("bp%0d_grant", c), 32'(grant_id), 32'h2);
      check($sformatf("bp%0d_data", c), 32'(Data_out), 32'h22);
      check($sformatf("bp%0d_wr", c), 32'(wr), 32'h0);
      check($sformatf("bp%0d_ack", c), 32'(s_ack), 32'h0);
    end
    full = 1'b0;
    #1;
    check("bp_release_wr", 32'(wr), 32'h1);
    check("bp_release_ack", 32'(s_ack), 32'h04);
    all_idle();
    cyc();
    check("bp_gap_wr", 32'(wr), 32'h0);
    check("bp_cnt", 32'(flit_cnt), 32'h6);
    cyc();
    check("bp_idle_wr", 32'(wr), 32'h0);
    check("bp_idle_cnt", 32'(flit_cnt), 32'h6);

    // Foreign routes are ignored
    set_port(0, 3'b001, 8'hA0);
    set_port(1, 3'b111, 8'hA1);
    set_port(2, 3'b001, 8'hA2);
    set_port(3, 3'b111, 8'hA3);
    set_port(4, 3'b001, 8'hA4);
    for (int c = 0; c < 5; c++) begin
      cyc();
      check($sformatf("foreign%0d_wr", c), 32'(wr), 32'h0);
      check($sformatf("foreign%0d_grant", c), 32'(grant_id), 32'h7);
    end
    check("foreign_cnt", 32'(flit_cnt), 32'h6);

    // Reset while stalled in SEND; ptr is 2 so port 3 wins first
    all_idle();
    full = 1'b1;
    set_port(0, 3'b000, 8'h0A);
    set_port(3, 3'b000, 8'h77);
    cyc();
    check("rsend_grant", 32'(grant_id), 32'h3);
    check("rsend_data", 32'(Data_out), 32'h77);
    rst = 1'b1;
    cyc();
    full = 1'b0;
    #1;
    check("rmid_grant", 32'(grant_id), 32'h7);
    check("rmid_data", 32'(Data_out), 32'h0);
    check("rmid_wr", 32'(wr), 32'h0);
    check("rmid_cnt", 32'(flit_cnt), 32'h0);
    rst = 1'b0;
    cyc();
    check("rpost_grant", 32'(grant_id), 32'h0);
    check("rpost_data", 32'(Data_out), 32'h0A);
    check("rpost_wr", 32'(wr), 32'h1);
    all_idle();
    cyc();
    check("rpost_cnt", 32'(flit_cnt), 32'h1);
    cyc();

    // Counter wrap: 255 more sends from port 0
    set_port(0, 3'b000, 8'h5A);
    repeat (254 * 3) cyc();
    check("wrap_255", 32'(flit_cnt), 32'hFF);
    repeat (3) cyc();
    check("wrap_0", 32'(flit_cnt), 32'h0);
    all_idle();
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, which sets the flit width.
REQ-002 The module SHALL have parameter N_PORT, default 5, which sets the number of requesting input controllers; index 0=local, 1=E, 2=W, 3=N, 4=S.
REQ-003 The module SHALL have parameter PORT_ID, default 3'b000, which is the 3-bit route code this output port serves (000 local, 001 E, 010 W, 011 N, 100 S).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port req_route, input, N_PORT*3 bits: the route code of each input controller, where slice i is [3i+2:3i]; 3'b111 means idle.
REQ-007 The module SHALL have port req_data, input, N_PORT*DATA_WIDTH bits: the flit of each input controller, where slice i is [DATA_WIDTH*i +: DATA_WIDTH].
REQ-008 The module SHALL have port full, input, 1 bit: the downstream output FIFO is full.
REQ-009 The module SHALL have port Data_out, output, DATA_WIDTH bits: the registered flit to the output FIFO.
REQ-010 The module SHALL have port wr, output, 1 bit: the write strobe to the output FIFO.
REQ-011 The module SHALL have port s_ack, output, N_PORT bits: a one-hot acknowledge to the granted input controller.
REQ-012 The module SHALL have port grant_id, output, 3 bits: the index of the current winner; 3'b111 when there is no grant.
REQ-013 The module SHALL have port flit_cnt, output, 8 bits: the count of flits written, wrapping.

Function
REQ-014 Requester i SHALL be valid when req_route slice i equals PORT_ID; the code 3'b111 and any other code SHALL be ignored.
REQ-015 The FSM SHALL have three states: IDLE, SEND and GAP.
REQ-016 In IDLE with at least one valid requester, the block SHALL select the winner by round-robin, searching indices ptr+1, ptr+2, ... modulo N_PORT, and the first valid index SHALL win.
REQ-017 On the IDLE->SEND edge, the block SHALL latch the winner into grant_id and latch req_data of the winner into Data_out.
REQ-018 In IDLE with no valid requester, the FSM SHALL stay in IDLE, grant_id SHALL be 3'b111, and Data_out SHALL hold its value.
REQ-019 In SEND, wr SHALL equal !full, combinationally.
REQ-020 In SEND, s_ack[grant_id] SHALL equal !full and all other s_ack bits SHALL be 0.
REQ-021 In SEND with full=0, the following SHALL occur at the clock edge: ptr <= grant_id; flit_cnt <= flit_cnt+1 (wrapping 255->0); state <= GAP.
REQ-022 In SEND with full=1, the block SHALL stall: it stays in SEND, holds wr=0 and s_ack=0, and holds Data_out and grant_id.
REQ-023 If the winner's request changes or is withdrawn during SEND, the latched flit SHALL still be sent exactly once.
REQ-024 GAP SHALL last exactly 1 cycle, with wr=0, s_ack=0 and grant_id=3'b111, and SHALL then go to IDLE; GAP lets the upstream FIFO/controller update so a flit is never sent twice.
REQ-025 Throughput SHALL be at most one flit per 3 cycles; the latency from a valid request in IDLE to the wr pulse SHALL be 1 cycle when full=0.
REQ-026 In any state other than SEND, wr SHALL be 0 and s_ack SHALL be 0.
REQ-027 Round-robin SHALL guarantee that a continuously valid requester is served within N_PORT grants.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set: state IDLE, ptr = N_PORT-1 (so index 0 has first priority), Data_out 0, grant_id 3'b111, flit_cnt 0.
REQ-029 While state=IDLE after reset, wr SHALL be 0 and s_ack SHALL be 0.
REQ-030 rst asserted during SEND SHALL abort the transfer: no wr pulse occurs on or after that edge and the latched flit is dropped.
REQ-031 rst SHALL take priority over all other inputs.

Verification
REQ-032 Single request: rst, then req_route[2:0]=000 with req_data[7:0]=8'h05 and full=0 -> next cycle Data_out=05, grant_id=0, wr=1, s_ack=5'b00001; then GAP; flit_cnt=1.
REQ-033 Round-robin: ports 1, 3 and 4 all continuously request 000 -> grant order 1, 3, 4, 1, with a wr pulse every 3 cycles.
REQ-034 Backpressure: full=1 for 4 cycles while in SEND -> wr=0, s_ack=0 and Data_out held; full->0 -> exactly one wr pulse and flit_cnt increments by 1.
REQ-035 Foreign routes: all ports present 001/111 to an instance with PORT_ID=000 -> the block stays in IDLE and wr never asserts.
REQ-036 Reset mid-SEND: with full=1 in SEND, assert rst -> grant_id=111, Data_out=0, no wr pulse; after release, port 0 wins first.
REQ-037 Counter wrap: 256 sends -> flit_cnt returns to 0.
